// File: rtl/req_retry_ctrl.sv
// Request/acknowledge retry controller driving a paired timer: re-issues the request on each
// timeout up to MAX_RETRIES times. Define REQ_RETRY_STICKY_FAIL_EN to make o_fail sticky.
module req_retry_ctrl #(
  parameter  int MAX_RETRIES = 3,
  localparam int CNT_W       = $clog2(MAX_RETRIES + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_go,
  input  logic             i_ack,
  input  logic             i_abort,
  input  logic             i_timeout,
  output logic             o_tmr_start,
  output logic             o_req,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_fail,
  output logic [CNT_W-1:0] o_retry_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RETRIES);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_d;
  logic             done_d;
  logic             fail_evt;
  logic             fail_d;
  logic             go_accept;
  logic             req_d;
  logic             tmr_start_d;
  logic             busy_d;

  // Next-state: abort outranks ack, ack outranks timeout
  always_comb begin
    state_d   = state_q;
    cnt_d     = o_retry_cnt;
    done_d    = 1'b0;
    fail_evt  = 1'b0;
    go_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_go) begin
          state_d   = ARM;
          cnt_d     = '0;
          go_accept = 1'b1;
        end
      end
      ARM: begin
        state_d = i_abort ? IDLE : WAIT;
      end
      WAIT: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (i_ack) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (i_timeout) begin
          if (o_retry_cnt == MAX_CNT) begin
            state_d  = IDLE;
            fail_evt = 1'b1;
          end else begin
            state_d = DROP;
            cnt_d   = o_retry_cnt + CNT_W'(1);
          end
        end
      end
      DROP: begin
        state_d = i_abort ? IDLE : ARM;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it
  always_comb begin
    req_d       = (state_d == ARM) || (state_d == WAIT);
    tmr_start_d = (state_d == ARM);
    busy_d      = (state_d != IDLE);
`ifdef REQ_RETRY_STICKY_FAIL_EN
    fail_d      = fail_evt | (o_fail & ~go_accept);
`else
    fail_d      = fail_evt;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      o_retry_cnt <= '0;
      o_tmr_start <= 1'b0;
      o_req       <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_fail      <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_retry_cnt <= cnt_d;
      o_tmr_start <= tmr_start_d;
      o_req       <= req_d;
      o_busy      <= busy_d;
      o_done      <= done_d;
      o_fail      <= fail_d;
    end
  end

endmodule

// File: tb/tb_req_retry_ctrl.sv
// Self-checking bench for req_retry_ctrl (MAX_RETRIES=2) with a behavioural timer and
// transaction-level reference model; honours REQ_RETRY_STICKY_FAIL_EN like the design.
module tb_req_retry_ctrl;

  localparam int MAXR    = 2;
  localparam int TIMEOUT = 4;
`ifdef REQ_RETRY_STICKY_FAIL_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       i_clk;
  logic       i_rst;
  logic       i_go;
  logic       i_ack;
  logic       i_abort;
  logic       i_timeout;
  logic       o_tmr_start;
  logic       o_req;
  logic       o_busy;
  logic       o_done;
  logic       o_fail;
  logic [1:0] o_retry_cnt;

  int checks = 0;
  int errors = 0;

  req_retry_ctrl #(.MAX_RETRIES(MAXR)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_go       (i_go),
    .i_ack      (i_ack),
    .i_abort    (i_abort),
    .i_timeout  (i_timeout),
    .o_tmr_start(o_tmr_start),
    .o_req      (o_req),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_fail     (o_fail),
    .o_retry_cnt(o_retry_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model: an active transaction, how far into the current attempt it is
  // (-1 = request-gap cycle, 0 = issue cycle, >0 = waiting), and retries consumed.
  bit m_busy;
  int m_age;
  int m_retries;
  bit m_done;
  bit m_fail_evt;
  bit m_fail_sticky;
  int tcnt = TIMEOUT;

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_retries = 0;
    m_done = 0; m_fail_evt = 0; m_fail_sticky = 0;
  endtask

  task automatic model_step(input bit go, input bit ack, input bit abort, input bit tmo);
    m_done = 0;
    m_fail_evt = 0;
    if (!m_busy) begin
      if (go) begin
        m_busy = 1; m_age = 0; m_retries = 0; m_fail_sticky = 0;
      end
    end else if (abort) m_busy = 0;
    else if (m_age < 0) m_age = 0;
    else if (m_age == 0) m_age = 1;
    else if (ack) begin
      m_busy = 0; m_done = 1;
    end else if (tmo) begin
      if (m_retries == MAXR) begin
        m_busy = 0; m_fail_evt = 1; m_fail_sticky = 1;
      end else begin
        m_retries++; m_age = -1;
      end
    end else m_age++;
  endtask

  // {req, tmr_start, busy, done, fail, retry_cnt}
  function automatic logic [6:0] exp_vec();
    logic req, ts, fl;
    req = m_busy && (m_age >= 0);
    ts  = m_busy && (m_age == 0);
    fl  = STICKY ? m_fail_sticky : m_fail_evt;
    return {req, ts, m_busy, m_done, fl, 2'(m_retries)};
  endfunction

  function automatic logic [6:0] dut_vec();
    return {o_req, o_tmr_start, o_busy, o_done, o_fail, o_retry_cnt};
  endfunction

  // Advance one clock: model consumes the pre-edge inputs, the timer sees the pre-edge
  // start pulse, then inputs return to idle with the timer's level on i_timeout.
  task automatic tick();
    logic ts;
    ts = o_tmr_start;
    model_step(i_go, i_ack, i_abort, i_timeout);
    @(posedge i_clk);
    #1;
    if (ts) tcnt = 1;
    else if (tcnt < TIMEOUT) tcnt++;
    i_go = 0; i_ack = 0; i_abort = 0;
    i_timeout = (tcnt >= TIMEOUT);
  endtask

  task automatic test_reset();
    i_rst = 0; i_go = 0; i_ack = 0; i_abort = 0; i_timeout = 1;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if (dut_vec() !== 7'b0) begin
      errors++; $display("FAIL reset_state got %b exp %b", dut_vec(), 7'b0);
    end
    i_rst = 1;
    tick();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_idle got %b exp %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_basic_ack();
    i_go = 1;
    tick();
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL basic_model cyc%0d got %b exp %b", c, dut_vec(), exp_vec());
      end
      checks++;
      if ({o_req, o_tmr_start, o_busy, o_done, o_retry_cnt} !==
          {(c <= 3), (c == 1), (c <= 3), (c == 4), 2'd0}) begin
        errors++; $display("FAIL basic_timeline cyc%0d got %b exp %b", c,
          {o_req, o_tmr_start, o_busy, o_done, o_retry_cnt},
          {(c <= 3), (c == 1), (c <= 3), (c == 4), 2'd0});
      end
      if (c == 3) i_ack = 1;
      if (c < 4) tick();
    end
  endtask

  task automatic test_retry_fail();
    int  arms = 0, gaps = 0, fails = 0, fail_cyc = -1;
    bit  prev_fail;
    prev_fail = o_fail;
    i_go = 1;
    tick();
    for (int c = 1; c <= 40; c++) begin
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL retry_model cyc%0d got %b exp %b", c, dut_vec(), exp_vec());
      end
      if (o_tmr_start) arms++;
      if (o_busy && !o_req) gaps++;
      if (o_fail && !prev_fail) begin
        fails++; fail_cyc = c;
      end
      prev_fail = o_fail;
      if (!o_busy) break;
      tick();
    end
    checks++;
    if ({arms, gaps, fails} !== {32'd3, 32'd2, 32'd1}) begin
      errors++; $display("FAIL retry_counts got arms=%0d gaps=%0d fails=%0d exp 3 2 1",
                         arms, gaps, fails);
    end
    checks++;
    if (fail_cyc != 18) begin
      errors++; $display("FAIL retry_fail_cycle got %0d exp 18", fail_cyc);
    end
    checks++;
    if (o_retry_cnt !== 2'd2) begin
      errors++; $display("FAIL retry_cnt got %0d exp 2", o_retry_cnt);
    end
  endtask

  task automatic test_fail_hold();
    for (int c = 0; c < 12; c++) begin
      if (c == 5) i_abort = 1;
      tick();
      checks++;
      if ({o_fail, dut_vec()} !== {STICKY, exp_vec()}) begin
        errors++; $display("FAIL fail_hold cyc%0d got fail=%b vec=%b exp fail=%b vec=%b",
                           c, o_fail, dut_vec(), STICKY, exp_vec());
      end
    end
    i_go = 1;
    tick();
    checks++;
    if ({o_fail, o_busy, o_retry_cnt} !== {1'b0, 1'b1, 2'd0} || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL fail_clear_on_go got %b exp %b", dut_vec(), exp_vec());
    end
    i_abort = 1;
    tick();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL fail_abort_arm got %b exp %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_ack_timeout();
    i_go = 1;
    tick();
    tick();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL ackto_wait got %b exp %b", dut_vec(), exp_vec());
    end
    i_ack = 1; i_timeout = 1;
    tick();
    checks++;
    if ({o_done, o_fail, o_busy, o_req} !== 4'b1000 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL ackto_success got %b exp %b", dut_vec(), exp_vec());
    end
    tick();
    checks++;
    if (o_done !== 1'b0 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL ackto_pulse_end got %b exp %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_abort();
    bit reached = 0;
    i_go = 1;
    tick();
    for (int c = 0; c < 30; c++) begin
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL abort_model cyc%0d got %b exp %b", c, dut_vec(), exp_vec());
      end
      if (m_retries == 1 && m_age >= 1) begin
        reached = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!reached) begin
      errors++; $display("FAIL abort_reach_wait got busy=%b cnt=%0d exp wait after one retry",
                         o_busy, o_retry_cnt);
    end
    i_abort = 1;
    tick();
    checks++;
    if ({o_busy, o_req, o_done, o_fail, o_retry_cnt} !== {4'b0000, 2'd1} ||
        dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL abort_to_idle got %b exp %b", dut_vec(), exp_vec());
    end
    for (int c = 0; c < 2; c++) begin
      i_abort = 1;
      tick();
      checks++;
      if (o_retry_cnt !== 2'd1 || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL abort_idle_hold got %b exp %b", dut_vec(), exp_vec());
      end
    end
    i_go = 1;
    tick();
    checks++;
    if ({o_req, o_retry_cnt} !== {1'b1, 2'd0} || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL abort_go_clears got %b exp %b", dut_vec(), exp_vec());
    end
    i_abort = 1;
    tick();
  endtask

  task automatic test_async_reset();
    i_go = 1;
    tick();
    i_go = 1;
    tick();
    checks++;
    if ({o_busy, o_tmr_start, o_req} !== 3'b101 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL arm_ignores_go got %b exp %b", dut_vec(), exp_vec());
    end
    tick();
    #2;
    i_rst = 0;
    #1;
    model_reset();
    checks++;
    if ({o_req, o_busy, o_tmr_start} !== 3'b000 || dut_vec() !== 7'b0) begin
      errors++; $display("FAIL async_reset got %b exp %b", dut_vec(), 7'b0);
    end
    @(posedge i_clk);
    #1;
    i_rst = 1;
    tick();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL post_reset_idle got %b exp %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      i_go    = ($urandom_range(0, 99) < 30);
      i_ack   = ($urandom_range(0, 99) < 12);
      i_abort = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 3) == 0) i_timeout = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc%0d got %b exp %b", c, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_ack();
    test_retry_fail();
    test_fail_hold();
    test_ack_timeout();
    test_abort();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
